// File: rtl/modn_pkg.sv
// -----------------------------------------------------------------------------
// modn_pkg
// Shared definitions for the modulo-N step counter: opcode encodings,
// run_state encodings and the step direction used by the arithmetic unit.
// No ports; imported by every file of the counter.
// -----------------------------------------------------------------------------
package modn_pkg;

  localparam int OPCODE_W = 3;
  localparam int STATE_W  = 2;

  // Command set sampled every cycle on the opcode input.
  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP       = 3'd0,
    OP_LOAD      = 3'd1,
    OP_STOP      = 3'd2,
    OP_INC       = 3'd3,
    OP_DEC       = 3'd4,
    OP_LOAD_STEP = 3'd5,
    OP_RSVD      = 3'd6,
    OP_CLEAR     = 3'd7
  } opcode_t;

  // Externally visible run state.
  typedef enum logic [STATE_W-1:0] {
    RUN_IDLE = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2
  } run_state_t;

  // Direction of a single count step.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } step_dir_t;

endpackage

// File: rtl/modn_step_counter_if.sv
// -----------------------------------------------------------------------------
// modn_step_counter_if
// Command/result bundle of the modulo-N step counter.
//   opcode    : 3-bit command, sampled every cycle
//   data      : operand for LOAD and LOAD_STEP
//   en_in     : count enable (cascading)
//   sat       : 0 = wrap mode, 1 = saturate mode
//   result    : registered counter value
//   y         : registered, 1 when result is even
//   tc        : one-cycle terminal-count pulse on wrap or clamp
//   run_state : IDLE / UP / DOWN
// master drives commands, slave (the counter) drives results.
// -----------------------------------------------------------------------------
interface modn_step_counter_if
  import modn_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic [OPCODE_W-1:0] opcode;
  logic [WIDTH-1:0]    data;
  logic                en_in;
  logic                sat;
  logic [WIDTH-1:0]    result;
  logic                y;
  logic                tc;
  run_state_t          run_state;

  modport master (
    output opcode, data, en_in, sat,
    input  result, y, tc, run_state
  );

  modport slave (
    input  opcode, data, en_in, sat,
    output result, y, tc, run_state
  );

endinterface

// File: rtl/modn_step_alu.sv
// -----------------------------------------------------------------------------
// modn_step_alu
// Combinational modulo-N step: value +/- step, wrapping or clamping to the
// range 0..N-1.
//   value      : current counter value (0..N-1)
//   step       : step size (0..N-1)
//   dir        : DIR_UP or DIR_DOWN
//   sat        : 0 = wrap, 1 = clamp at N-1 (up) or 0 (down)
//   next_value : value after the step
//   tc_next    : 1 when the step wrapped or clamped
// -----------------------------------------------------------------------------
module modn_step_alu
  import modn_pkg::*;
#(
  parameter int N     = 9,
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] step,
  input  step_dir_t        dir,
  input  logic             sat,
  output logic [WIDTH-1:0] next_value,
  output logic             tc_next
);

  // One extra bit so N itself (up to 2^WIDTH) and value+step / value+N
  // (at most 2N-2) are representable without overflow.
  localparam logic [WIDTH:0] N_EXT = (WIDTH+1)'(N);

  logic [WIDTH:0] val_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum;

  assign val_ext  = {1'b0, value};
  assign step_ext = {1'b0, step};

  // A zero step never crosses a boundary, so it falls out of both branches
  // with value unchanged and tc_next low.
  always_comb begin
    next_value = value;
    tc_next    = 1'b0;
    sum        = '0;
    if (dir == DIR_UP) begin
      sum = val_ext + step_ext;
      if (sum >= N_EXT) begin
        tc_next    = 1'b1;
        next_value = sat ? WIDTH'(N_EXT - 1'b1) : WIDTH'(sum - N_EXT);
      end else begin
        next_value = WIDTH'(sum);
      end
    end else begin
      if (val_ext >= step_ext) begin
        next_value = WIDTH'(val_ext - step_ext);
      end else begin
        tc_next    = 1'b1;
        next_value = sat ? '0 : WIDTH'(val_ext + N_EXT - step_ext);
      end
    end
  end

endmodule

// File: rtl/modn_step_counter.sv
// -----------------------------------------------------------------------------
// modn_step_counter
// Modulo-N up/down counter with programmable step, wrap or saturate mode,
// count enable and a registered terminal-count pulse.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : modn_step_counter_if.slave (opcode, data, en_in, sat in;
//           result, y, tc, run_state out)
// Parameters: N (modulus, 2..2^WIDTH), WIDTH (data/step/result width).
// -----------------------------------------------------------------------------
module modn_step_counter
  import modn_pkg::*;
#(
  parameter int N     = 9,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  modn_step_counter_if.slave    bus
);

  localparam logic [WIDTH:0] N_EXT = (WIDTH+1)'(N);

  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] step_r;
  run_state_t       run_state;
  logic             tc_r;
  logic             y_r;

  logic [WIDTH-1:0] value_d;
  logic [WIDTH-1:0] step_d;
  run_state_t       state_d;
  logic             tc_d;

  opcode_t          op;
  logic             running;
  logic             do_step;
  step_dir_t        step_dir;
  logic [WIDTH-1:0] data_mod;
  logic [WIDTH-1:0] alu_value;
  logic             alu_tc;

  assign op       = opcode_t'(bus.opcode);
  assign running  = (run_state != RUN_IDLE);
  assign data_mod = WIDTH'({1'b0, bus.data} % N_EXT);

  // The step always uses the registered step_r, so a LOAD_STEP while running
  // counts with the old step and the new one applies from the next cycle.
  modn_step_alu #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_alu (
    .value      (value),
    .step       (step_r),
    .dir        (step_dir),
    .sat        (bus.sat),
    .next_value (alu_value),
    .tc_next    (alu_tc)
  );

  // Opcode decode and next-state selection. INC/DEC set the direction for
  // the step they may take in the same cycle; otherwise the direction follows
  // the current run_state. A clamp in saturate mode ends the run.
  always_comb begin
    value_d  = value;
    step_d   = step_r;
    state_d  = run_state;
    tc_d     = 1'b0;
    do_step  = 1'b0;
    step_dir = (run_state == RUN_DOWN) ? DIR_DOWN : DIR_UP;
    unique case (op)
      OP_LOAD: value_d = data_mod;
      OP_STOP: state_d = RUN_IDLE;
      OP_INC: begin
        state_d  = RUN_UP;
        step_dir = DIR_UP;
        do_step  = bus.en_in;
      end
      OP_DEC: begin
        state_d  = RUN_DOWN;
        step_dir = DIR_DOWN;
        do_step  = bus.en_in;
      end
      OP_LOAD_STEP: begin
        step_d  = data_mod;
        do_step = running && bus.en_in;
      end
      OP_CLEAR: begin
        value_d = '0;
        state_d = RUN_IDLE;
      end
      default: do_step = running && bus.en_in;
    endcase
    if (do_step) begin
      value_d = alu_value;
      tc_d    = alu_tc;
      if (alu_tc && bus.sat) begin
        state_d = RUN_IDLE;
      end
    end
  end

  // All outputs are registered on the same edge; y is taken from the value
  // being written so it always matches the new result. Reset wins over any
  // opcode and drops a pending tc.
  always_ff @(posedge clk) begin
    if (reset) begin
      value     <= '0;
      step_r    <= WIDTH'(1);
      run_state <= RUN_IDLE;
      tc_r      <= 1'b0;
      y_r       <= 1'b1;
    end else begin
      value     <= value_d;
      step_r    <= step_d;
      run_state <= state_d;
      tc_r      <= tc_d;
      y_r       <= ~value_d[0];
    end
  end

  assign bus.result    = value;
  assign bus.y         = y_r;
  assign bus.tc        = tc_r;
  assign bus.run_state = run_state;

endmodule

// File: tb/tb_modn_step_counter.sv
// -----------------------------------------------------------------------------
// tb_modn_step_counter
// Self-checking bench for modn_step_counter with N=9, WIDTH=4: a table of
// directed vectors, hand-written multi-cycle sequences, then random
// stimulus compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_modn_step_counter;

  localparam int N     = 9;
  localparam int WIDTH = 4;

  logic clk;
  logic reset;

  modn_step_counter_if #(.WIDTH(WIDTH)) bus();

  modn_step_counter #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: value, step, mode (0 idle, 1 up, 2 down), tc.
  int m_val   = 0;
  int m_step  = 1;
  int m_state = 0;
  int m_tc    = 0;

  typedef struct {
    logic       rst;
    logic [2:0] op;
    logic [3:0] data;
    logic       en;
    logic       sat;
    int         exp_result;
    int         exp_y;
    int         exp_tc;
    int         exp_state;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [2:0] op, logic [3:0] data,
                              logic en, logic sat, int r, int y, int tc,
                              int st, string name);
    vec_t v;
    v.rst = rst; v.op = op; v.data = data; v.en = en; v.sat = sat;
    v.exp_result = r; v.exp_y = y; v.exp_tc = tc; v.exp_state = st;
    v.name = name;
    return v;
  endfunction

  // Model one clock edge from the counter's rules using plain arithmetic.
  task automatic modelStep(input logic rst, input int op, input int d,
                           input logic en, input logic s);
    int  t;
    int  new_step;
    bit  stepping;
    if (rst) begin
      m_val = 0; m_step = 1; m_state = 0; m_tc = 0;
      return;
    end
    m_tc     = 0;
    stepping = 0;
    new_step = m_step;
    case (op)
      1: m_val = d % N;
      2: m_state = 0;
      3: begin m_state = 1; stepping = en; end
      4: begin m_state = 2; stepping = en; end
      5: begin new_step = d % N; stepping = (m_state != 0) && en; end
      7: begin m_val = 0; m_state = 0; end
      default: stepping = (m_state != 0) && en;
    endcase
    if (stepping) begin
      if (m_state == 1) begin
        t = m_val + m_step;
        if (t >= N) begin
          m_tc = 1;
          if (s) begin m_val = N - 1; m_state = 0; end
          else   m_val = t - N;
        end else m_val = t;
      end else begin
        t = m_val - m_step;
        if (t < 0) begin
          m_tc = 1;
          if (s) begin m_val = 0; m_state = 0; end
          else   m_val = t + N;
        end else m_val = t;
      end
    end
    m_step = new_step;
  endtask

  // Drive one cycle of inputs, advance the model with the same edge and
  // settle 1 time unit past the edge before anything is sampled.
  task automatic applyStimulus(input logic rst, input logic [2:0] op,
                               input logic [3:0] d, input logic en,
                               input logic s);
    reset      = rst;
    bus.opcode = op;
    bus.data   = d;
    bus.en_in  = en;
    bus.sat    = s;
    @(posedge clk);
    modelStep(rst, int'(op), int'(d), en, s);
    #1;
  endtask

  task automatic checkField(input string name, input string field,
                            input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: %s got %0d expected %0d", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int exp_r,
                             input int exp_y, input int exp_tc,
                             input int exp_st);
    checkField(name, "result",    int'(bus.result),    exp_r);
    checkField(name, "y",         int'(bus.y),         exp_y);
    checkField(name, "tc",        int'(bus.tc),        exp_tc);
    checkField(name, "run_state", int'(bus.run_state), exp_st);
  endtask

  initial begin
    reset      = 1'b1;
    bus.opcode = 3'd0;
    bus.data   = '0;
    bus.en_in  = 1'b1;
    bus.sat    = 1'b0;

    // Directed vectors: rst, op, data, en, sat -> result, y, tc, run_state.
    vecs.push_back(mk(1, 3'd0,  0, 1, 0, 0, 1, 0, 0, "reset"));
    vecs.push_back(mk(0, 3'd1, 13, 1, 0, 4, 1, 0, 0, "load13"));
    vecs.push_back(mk(0, 3'd5,  2, 1, 0, 4, 1, 0, 0, "ldstep2"));
    vecs.push_back(mk(0, 3'd1,  7, 1, 0, 7, 0, 0, 0, "load7"));
    vecs.push_back(mk(0, 3'd3,  0, 1, 0, 0, 1, 1, 1, "inc_wrap"));
    vecs.push_back(mk(0, 3'd0,  0, 1, 0, 2, 1, 0, 1, "up_2"));
    vecs.push_back(mk(0, 3'd0,  0, 1, 0, 4, 1, 0, 1, "up_4"));
    vecs.push_back(mk(0, 3'd2,  0, 1, 0, 4, 1, 0, 0, "stop"));
    vecs.push_back(mk(0, 3'd5,  3, 1, 1, 4, 1, 0, 0, "ldstep3"));
    vecs.push_back(mk(0, 3'd1,  7, 1, 1, 7, 0, 0, 0, "load7_sat"));
    vecs.push_back(mk(0, 3'd3,  0, 1, 1, 8, 1, 1, 0, "inc_clamp"));
    vecs.push_back(mk(0, 3'd0,  0, 1, 1, 8, 1, 0, 0, "hold8_a"));
    vecs.push_back(mk(0, 3'd0,  0, 1, 1, 8, 1, 0, 0, "hold8_b"));
    vecs.push_back(mk(0, 3'd5,  2, 1, 0, 8, 1, 0, 0, "ldstep2_b"));
    vecs.push_back(mk(0, 3'd1,  1, 1, 0, 1, 0, 0, 0, "load1"));
    vecs.push_back(mk(0, 3'd4,  0, 1, 0, 8, 1, 1, 2, "dec_wrap"));
    vecs.push_back(mk(0, 3'd0,  0, 1, 0, 6, 1, 0, 2, "down_6"));
    vecs.push_back(mk(0, 3'd7,  0, 1, 0, 0, 1, 0, 0, "clear"));
    vecs.push_back(mk(0, 3'd5,  0, 1, 0, 0, 1, 0, 0, "ldstep0"));
    vecs.push_back(mk(0, 3'd3,  0, 1, 0, 0, 1, 0, 1, "inc_step0"));
    vecs.push_back(mk(0, 3'd5,  9, 1, 0, 0, 1, 0, 1, "ldstep9"));
    vecs.push_back(mk(0, 3'd5, 15, 1, 0, 0, 1, 0, 1, "ldstep15_old"));
    vecs.push_back(mk(0, 3'd0,  0, 1, 0, 6, 1, 0, 1, "up_step6"));
    vecs.push_back(mk(0, 3'd4,  0, 1, 1, 0, 1, 0, 2, "dec_exact0"));
    vecs.push_back(mk(0, 3'd0,  0, 1, 1, 0, 1, 1, 0, "dec_clamp0"));
    vecs.push_back(mk(0, 3'd6,  0, 1, 1, 0, 1, 0, 0, "reserved"));
    vecs.push_back(mk(0, 3'd1, 15, 1, 0, 6, 1, 0, 0, "load15"));
    vecs.push_back(mk(0, 3'd3,  0, 0, 0, 6, 1, 0, 1, "inc_en0"));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].data, vecs[i].en,
                    vecs[i].sat);
      checkOutput(vecs[i].name, vecs[i].exp_result, vecs[i].exp_y,
                  vecs[i].exp_tc, vecs[i].exp_state);
    end

    // Enable held low while running: value holds, then STOP idles.
    applyStimulus(1, 3'd0, 0, 1, 0);
    checkOutput("hold_reset", 0, 1, 0, 0);
    applyStimulus(0, 3'd5, 2, 1, 0);
    applyStimulus(0, 3'd1, 1, 1, 0);
    checkOutput("hold_load1", 1, 0, 0, 0);
    applyStimulus(0, 3'd3, 0, 1, 0);
    checkOutput("hold_inc", 3, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 3'd0, 0, 0, 0);
      checkOutput("hold_en0", 3, 0, 0, 1);
    end
    applyStimulus(0, 3'd2, 0, 1, 0);
    checkOutput("hold_stop", 3, 0, 0, 0);

    // Reset mid-run aborts without tc and restores step 1.
    applyStimulus(0, 3'd1, 3, 1, 0);
    applyStimulus(0, 3'd3, 0, 1, 0);
    checkOutput("midrun_up5", 5, 0, 0, 1);
    applyStimulus(1, 3'd3, 0, 1, 0);
    checkOutput("midrun_reset", 0, 1, 0, 0);
    applyStimulus(0, 3'd3, 0, 1, 0);
    checkOutput("midrun_step1", 1, 0, 0, 1);
    applyStimulus(0, 3'd0, 0, 1, 0);
    checkOutput("midrun_step1b", 2, 1, 0, 1);

    // Random stimulus against the reference model.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    3'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)));
      checkOutput("random", m_val, ((m_val % 2) == 0) ? 1 : 0, m_tc, m_state);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
